// File: rtl/acc_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_bank_if
// Description : Request/response bundle between the datapath and acc_bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_bank_if #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2
);
    logic [SELW-1:0]  acc_sel;
    logic             acc_wr;
    logic [WIDTH-1:0] in_data;
    logic             in_carry;
    logic             in_zero;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_err;

    modport master (
        output acc_sel, acc_wr, in_data, in_carry, in_zero, push, pop, clr_err,
        input  out_data, out_carry, out_zero, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  acc_sel, acc_wr, in_data, in_carry, in_zero, push, pop, clr_err,
        output out_data, out_carry, out_zero, stk_full, stk_empty, stk_err
    );
endinterface
`default_nettype wire

// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
// Module      : acc_bank
// Description : NACC accumulators with carry/zero flags and a context stack.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_bank #(
    parameter int WIDTH = 8,
    parameter int NACC  = 4,
    parameter int SELW  = 2,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    acc_bank_if.slave  bus
);
    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int ENTW = WIDTH + 2;

    logic [WIDTH-1:0] r_acc [NACC];
    logic [NACC-1:0]  r_carry;
    logic [NACC-1:0]  r_zero;
    logic [ENTW-1:0]  r_stk [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic             r_err;

    logic             w_sel_ok;
    logic [ENTW-1:0]  w_cur;
    logic [ENTW-1:0]  w_top;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_err_set;

    // Selects at or beyond NACC match no entry, so they read as zero.
    always_comb begin
        w_sel_ok = 1'b0;
        w_cur    = '0;
        for (int i = 0; i < NACC; i++) begin
            if (bus.acc_sel == SELW'(i)) begin
                w_sel_ok = 1'b1;
                w_cur    = {r_acc[i], r_carry[i], r_zero[i]};
            end
        end
    end

    always_comb begin
        w_top = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (r_sp == SPW'(j + 1)) begin
                w_top = r_stk[j];
            end
        end
    end

    assign w_full    = (r_sp == SPW'(DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_push    = bus.push & ~bus.pop;
    assign w_pop     = bus.pop & ~bus.push;
    assign w_do_push = w_sel_ok & w_push & ~w_full;
    assign w_do_pop  = w_sel_ok & w_pop & ~w_empty;
    assign w_err_set = (w_sel_ok & w_push & w_full)
                     | (w_sel_ok & w_pop & w_empty)
                     | (~w_sel_ok & (bus.acc_wr | bus.push | bus.pop));

    assign bus.out_data  = w_cur[ENTW-1:2];
    assign bus.out_carry = w_cur[1];
    assign bus.out_zero  = w_cur[0];
    assign bus.stk_full  = w_full;
    assign bus.stk_empty = w_empty;
    assign bus.stk_err   = r_err;

    // A write in the same cycle as a pop takes priority; the popped entry is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NACC; i++) begin
                r_acc[i] <= '0;
            end
            r_carry <= '0;
            r_zero  <= '0;
        end else begin
            for (int i = 0; i < NACC; i++) begin
                if (w_sel_ok && (bus.acc_sel == SELW'(i))) begin
                    if (bus.acc_wr) begin
                        r_acc[i]   <= bus.in_data;
                        r_carry[i] <= bus.in_carry;
                        r_zero[i]  <= bus.in_zero;
                    end else if (w_do_pop) begin
                        {r_acc[i], r_carry[i], r_zero[i]} <= w_top;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_do_pop) begin
                r_sp <= r_sp - SPW'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    // Stack storage carries no reset; entries above sp are never observed.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (w_do_push && (r_sp == SPW'(j))) begin
                r_stk[j] <= w_cur;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank for the 8-bit processor datapath. It holds NACC independent accumulators of WIDTH bits, each with its own carry and zero flags. A context stack of DEPTH entries saves and restores the selected accumulator and its flags for subroutine and interrupt entry. It sits between the ALU result mux and the ALU A-operand/flag inputs.

## Interface
Parameters:
- WIDTH, 8, data width of each accumulator
- NACC, 4, number of accumulators (≥2)
- SELW, 2, width of the accumulator select; 2^SELW ≥ NACC
- DEPTH, 4, number of context-stack entries (≥2)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- acc_sel  in  SELW  selects the accumulator for read, write, push and pop
- acc_wr  in  1  write in_data, in_carry and in_zero into accumulator acc_sel
- in_data  in  WIDTH  result from the ALU mux
- in_carry  in  1  carry flag from the ALU
- in_zero  in  1  zero flag from the ALU
- push  in  1  save {acc[acc_sel], carry, zero} to the stack
- pop  in  1  restore the top stack entry into accumulator acc_sel
- clr_err  in  1  clear the sticky stk_err
- out_data  out  WIDTH  acc[acc_sel], combinational read of registered state
- out_carry  out  1  carry flag of acc[acc_sel]
- out_zero  out  1  zero flag of acc[acc_sel]
- stk_full  out  1  stack holds DEPTH entries
- stk_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky: push while full, pop while empty, or acc_sel ≥ NACC with any request

## Operation
- Reset (rst=0): all accumulators and flags are 0, and the stack pointer is 0.
  - Resulting outputs: out_data=0, out_carry=0, out_zero=0, stk_empty=1, stk_full=0, stk_err=0.
  - Stack entry contents are don't-care.
- Write: when acc_wr=1, acc[acc_sel], carry[acc_sel] and zero[acc_sel] load the inputs. Other accumulators hold.
- Push, not full: the entry at sp takes {acc[acc_sel], carry, zero}, then sp increments.
  - The pushed value is the pre-edge value, even when acc_wr=1 in the same cycle; the write still happens.
- Pop, not empty: sp decrements, and entry sp-1 loads into acc[acc_sel] and its flags.
  - If acc_wr=1 in the same cycle, acc_wr wins the accumulator update. The pop still decrements sp and the popped data is discarded.
- push=1 and pop=1 together: no state change and no error.
- Push when full or pop when empty: no stack or accumulator change, and stk_err is set. Any acc_wr in that cycle is still performed.
- acc_sel ≥ NACC: reads return 0 and flags 0. acc_wr, push and pop are ignored, and stk_err is set if any of them was asserted.
- stk_err is sticky and clears only on clr_err=1 or reset. If a set condition and clr_err occur in the same cycle, set wins.
- Flags are stored, not recomputed. in_zero is latched as given, even if it is inconsistent with in_data.
- The stack pointer is $clog2(DEPTH+1) bits wide. stk_full = (sp==DEPTH) and stk_empty = (sp==0), both decoded from registers.

## Timing
- Writes, pushes and pops take effect at the rising edge. Updated out_* and stack status are visible in the following cycle; there is no bypass from in_data to out_data.
- Read latency is zero: out_* follow acc_sel combinationally within the cycle.
- No handshake. Requests are single-cycle pulses or level-held, and each cycle with a request counts as one operation.
- Reset asserted mid-operation clears state immediately, asynchronously. Requests in the deassertion cycle are honoured from the next rising edge.

## Test plan
- Reset, then write 8'hA5 with carry=1 and zero=0 to acc 2 → next cycle with acc_sel=2: out_data=A5, out_carry=1, out_zero=0. With acc_sel=0: out_data=00, out_carry=0, out_zero=0.
- Write 8'h11 to acc 1, push, write 8'h22 to acc 1, pop on acc 1 → out_data=11 and stk_empty=1.
- Push 4 times (DEPTH=4) → stk_full=1. 5th push → stk_err=1 and sp unchanged. clr_err → stk_err=0.
- Pop on an empty stack → stk_err=1 and accumulator unchanged. Pop with acc_wr=1 and in_data=8'h77 on a non-empty stack → acc=77 and sp decrements.
- Push and pop in the same cycle → sp unchanged and stk_err=0. Push with acc_wr=1 (acc=8'h10, in_data=8'h20), then pop → acc returns to 10.
- Assert rst mid-sequence with the stack half full → all outputs return to reset values asynchronously, without waiting for a clock edge.
